// File: rtl/lsu_dmem_pkg.sv
// lsu_dmem shared definitions: access size codes, FSM states, lane mask.
// Imported by lsu_align and lsu_dmem.
package lsu_dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of `size` at byte offset `off`.
  // `off` is expected to be naturally aligned for half/word.
  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for lsu_dmem: store data shift, lane mask, load extension.
// Ports: size_i/off_i/unsigned_i, wdata_i/rword_i in; mask_o/wdata_o/rdata_o out.
module lsu_align
  import lsu_dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [31:0] rsh;

  always_comb begin
    sh      = {off_i, 3'b000};
    mask_o  = lane_mask(size_i, off_i);
    wdata_o = wdata_i << sh;
    rsh     = rword_i >> sh;
    rdata_o = 32'd0;
    unique case (size_i)
      SZ_B: rdata_o = unsigned_i ? {24'd0, rsh[7:0]}
                                 : {{24{rsh[7]}}, rsh[7:0]};
      SZ_H: rdata_o = unsigned_i ? {16'd0, rsh[15:0]}
                                 : {{16{rsh[15]}}, rsh[15:0]};
      SZ_W: rdata_o = rsh;
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit with a private word-organised data memory and fixed latency.
// Ports: clk, rst (async high), req_* handshake in, resp_* strobe out, verify = word 0.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned half/word instead of aligning.
module lsu_dmem
  import lsu_dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] verify
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'((LAT > 0) ? LAT - 1 : 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_uns;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [1:0]  off;
  logic        mis, oor, ill, err;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  logic [31:0] wsh;
  logic [31:0] rext;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign verify     = mem_q[0];

  // With zero latency the access happens on the acceptance edge itself,
  // so the live request fields are used instead of the captured copy.
  assign a_we    = (LAT == 0) ? req_we       : we_q;
  assign a_size  = (LAT == 0) ? req_size     : size_q;
  assign a_uns   = (LAT == 0) ? req_unsigned : uns_q;
  assign a_addr  = (LAT == 0) ? req_addr     : addr_q;
  assign a_wdata = (LAT == 0) ? req_wdata    : wdata_q;

  assign idx = a_addr[AW+1:2];
  assign oor = (a_addr >> (AW + 2)) != 32'd0;
  assign ill = (a_size == SZ_X);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((a_size == SZ_H) & a_addr[0]) |
               ((a_size == SZ_W) & (a_addr[1:0] != 2'b00));
  assign off = a_addr[1:0];
`else
  assign mis = 1'b0;
  always_comb begin
    off = a_addr[1:0];
    unique case (a_size)
      SZ_H:    off = {a_addr[1], 1'b0};
      SZ_W:    off = 2'b00;
      default: off = a_addr[1:0];
    endcase
  end
`endif

  assign err = ill | oor | mis;

  lsu_align u_align (
    .size_i     (a_size),
    .off_i      (off),
    .unsigned_i (a_uns),
    .wdata_i    (a_wdata),
    .rword_i    (mem_q[idx]),
    .mask_o     (mask),
    .wdata_o    (wsh),
    .rdata_o    (rext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'd0;
          state_d = (LAT == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_M1) state_d = RESP;
        else cnt_d = 4'(cnt_q + 4'd1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RESP lasts one cycle, so state_d == RESP marks the access edge.
  always_comb begin
    rdata_d = 32'd0;
    err_d   = 1'b0;
    if (state_d == RESP) begin
      err_d   = err;
      rdata_d = (!a_we && !err) ? rext : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_d == RESP && a_we && !err) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: directed + random traffic against a byte-level model,
// plus a LAT=3 instance for latency and reset-abort behaviour.
module tb_lsu_dmem;

  localparam int DEPTH = 256;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] verify;

  logic        rst2 = 1'b1;
  logic        v2 = 1'b0;
  logic        we2 = 1'b1;
  logic [1:0]  sz2 = 2'b10;
  logic [31:0] addr2 = 32'd0;
  logic [31:0] wd2 = 32'd0;
  logic        rdy2, rv2, re2;
  logic [31:0] rd2, vf2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] vfy;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mdl [DEPTH];

  lsu_dmem #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .verify(verify)
  );

  lsu_dmem #(.DEPTH(DEPTH), .LAT(3)) dut3 (
    .clk(clk), .rst(rst2),
    .req_valid(v2), .req_ready(rdy2),
    .req_we(we2), .req_size(sz2),
    .req_unsigned(1'b0), .req_addr(addr2),
    .req_wdata(wd2),
    .resp_valid(rv2), .resp_rdata(rd2),
    .resp_err(re2), .verify(vf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain byte arithmetic over a word array.
  task automatic model(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    logic [31:0] a, mask, v;
    int nb, w, sh;
    err = 1'b0;
    rd  = 32'd0;
    a   = addr;
    nb  = 1;
    case (size)
      2'd0: nb = 1;
      2'd1: begin
        nb = 2;
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % 2 != 0) err = 1'b1;
`endif
        a = addr - (addr % 2);
      end
      2'd2: begin
        nb = 4;
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % 4 != 0) err = 1'b1;
`endif
        a = addr - (addr % 4);
      end
      default: err = 1'b1;
    endcase
    if (a >= 32'(DEPTH * 4)) err = 1'b1;
    if (!err) begin
      w    = int'(a / 4);
      sh   = int'(a % 4) * 8;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (we) begin
        mdl[w] = (mdl[w] & ~(mask << sh)) | ((wdata & mask) << sh);
      end else begin
        v = (mdl[w] >> sh) & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    exp_t e;
    @(negedge clk);
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end else begin
      model(we, size, uns, addr, wdata, e.rd, e.err);
      e.vfy = mdl[0];
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("rdata", resp_rdata, e.rd);
        chk("err", {31'd0, resp_err}, {31'd0, e.err});
        chk("verify", verify, e.vfy);
        chk("latency", 32'(cyc + 1 - e.acc), 32'(LAT + 1));
      end
    end
  end

  initial begin
    int n, seen;
    logic [1:0] sz;
    logic [31:0] ad;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'd0);
    chk("post_rst_err", {31'd0, resp_err}, 32'd0);
    chk("post_rst_verify", verify, 32'd0);

    issue(1, 2'd2, 0, 32'h0, 32'hDEADBEEF);
    issue(0, 2'd2, 0, 32'h0, 32'h0);
    issue(1, 2'd0, 0, 32'h1, 32'h55);
    issue(0, 2'd0, 0, 32'h3, 32'h0);
    issue(0, 2'd0, 1, 32'h3, 32'h0);
    issue(1, 2'd1, 0, 32'h2, 32'h8001);
    issue(0, 2'd1, 0, 32'h2, 32'h0);
    issue(0, 2'd1, 1, 32'h2, 32'h0);
    issue(1, 2'd2, 0, 32'h400, 32'h12345678);
    issue(1, 2'd3, 0, 32'h0, 32'hFFFFFFFF);
    issue(0, 2'd3, 0, 32'h4, 32'h0);
    issue(1, 2'd2, 0, 32'h2, 32'h12345678);
    issue(0, 2'd2, 0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        ad = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      else if ($urandom_range(0, 3) == 0)
        ad = 32'($urandom_range(0, DEPTH * 4 - 1));
      else
        ad = 32'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            ad, $urandom);
    end

    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    // LAT=3: full store, latency measured in edges after acceptance.
    @(negedge clk);
    wd2 = 32'hCAFEF00D;
    v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    n = 1;
    while (!rv2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat3_latency", 32'(n), 32'd4);
    chk("lat3_err", {31'd0, re2}, 32'd0);
    @(negedge clk);
    chk("lat3_verify", vf2, 32'hCAFEF00D);

    // LAT=3: reset in the second WAIT cycle aborts the store.
    wd2 = 32'h11112222;
    v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    seen = 0;
    @(negedge clk);
    if (rv2) seen++;
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv2) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    chk("abort_verify", vf2, 32'd0);
    chk("abort_ready", {31'd0, rdy2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 Parameter DEPTH, default 256, memory depth in 32-bit words; power of two, 4..65536.
REQ-002 Parameter LAT, default 1, wait cycles between request acceptance and response; 0..15.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 Port resp_valid  output  1  one-cycle response strobe.
REQ-013 Port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 Port resp_err  output  1  request faulted; qualified by resp_valid.
REQ-015 Port verify  output  32  combinational copy of memory word 0 for bench observation.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; the request is accepted on a rising edge when req_valid and req_ready are both 1, and all request fields are captured at that edge.
REQ-018 On acceptance with LAT=0 the FSM SHALL go IDLE->RESP; with LAT>0 it SHALL go IDLE->WAIT, hold WAIT for exactly LAT cycles, then go to RESP.
REQ-019 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; resp_valid SHALL be 1 exactly LAT+1 cycles after the acceptance edge, and the response cannot be back-pressured.
REQ-020 A store SHALL commit its byte lanes on the edge entering RESP, and the load data returned in RESP SHALL be read on that same edge.
REQ-021 Byte lanes: byte SHALL write lane addr[1:0]; half SHALL write lanes addr[1]*2 and +1; word SHALL write all four; unwritten lanes SHALL be preserved.
REQ-022 Loads SHALL select the same lanes and shift them to bit 0, then extend to 32 bits according to req_unsigned.
REQ-023 The word index SHALL be addr[log2(DEPTH)+1:2]; an address >= DEPTH*4 SHALL set resp_err=1, suppress any write and force resp_rdata=0.
REQ-024 req_size=11 SHALL set resp_err=1 with no write and resp_rdata=0.
REQ-025 While not in IDLE, req_valid SHALL be ignored; a request held across a response SHALL be accepted on its first IDLE cycle.

Reset
REQ-026 rst=1 SHALL immediately force the FSM to IDLE, clear the wait counter, and set resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=1 after release.
REQ-027 Memory contents SHALL be cleared to zero at reset; reset during WAIT SHALL abort the request so that no write occurs.

Configuration
REQ-028 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL set resp_err=1, suppress the write and return 0.
REQ-029 Without LSU_MISALIGN_TRAP_EN, the low address bits SHALL be forced to natural alignment (half clears bit 0, word clears bits 1:0) and the access proceeds normally with no error.

Structure
REQ-030 A shared package SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the FSM state typedef and the function computing the lane mask.
REQ-031 The lane/extension logic SHALL be a sub-module lsu_align (combinational: size, offset, unsigned in; mask, shifted wdata, extended rdata out); the FSM and storage stay in lsu_dmem.

Verification (defaults DEPTH=256, LAT=1 unless stated)
REQ-032 Store word 0xDEADBEEF to addr 0x0, then load word from 0x0 -> resp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, verify=0xDEADBEEF.
REQ-033 Following REQ-032, store byte 0x55 to addr 0x1, then load byte signed from 0x3 -> verify=0xDEAD55EF, rdata=0xFFFFFFDE; load byte unsigned from 0x3 -> rdata=0x000000DE.
REQ-034 Load half signed from 0x2 holding 0x8001 -> rdata=0xFFFF8001; the same load unsigned -> rdata=0x00008001.
REQ-035 Store word to addr 0x400 (= DEPTH*4) -> resp_err=1, rdata=0, memory unchanged; a request with req_size=11 -> resp_err=1.
REQ-036 With LSU_MISALIGN_TRAP_EN, store word to 0x2 -> resp_err=1 and no write; without the macro, the same store -> resp_err=0 and word 0 written.
REQ-037 LAT=3: assert rst in the second WAIT cycle of a store -> resp_valid stays 0, target word unchanged, req_ready=1 after rst falls.
